// File: rtl/mem_stage_lsu_pkg.sv
// Shared RV32I types for the MEM-stage load/store unit: word/mask types,
// funct3 encodings and the LSU handshake state.
package mem_stage_lsu_pkg;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Lane logic for the LSU: byte enables and lane-replicated store data,
// load extraction with sign/zero extension, misalignment and illegal-funct3 flags.
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic        i_store,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_mbe,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [31:0] w_shifted;

  // Decode funct3 into lane enables, store replication and load extension
  always_comb begin
    w_shifted    = i_rdata >> {i_offset, 3'b000};
    o_mbe        = 4'b1111;
    o_wdata      = 32'h0000_0000;
    o_ldata      = 32'h0000_0000;
    o_misaligned = 1'b0;
    o_illegal    = 1'b0;
    if (i_store) begin
      case (i_funct3)
        SB: begin
          o_mbe   = 4'b0001 << i_offset;
          o_wdata = {4{i_wdata[7:0]}};
        end
        SH: begin
          o_mbe        = 4'b0011 << i_offset;
          o_wdata      = {2{i_wdata[15:0]}};
          o_misaligned = i_offset[0];
        end
        SW: begin
          o_wdata      = i_wdata;
          o_misaligned = |i_offset;
        end
        default: o_illegal = 1'b1;
      endcase
    end else begin
      case (i_funct3)
        LB:  o_ldata = {{24{w_shifted[7]}}, w_shifted[7:0]};
        LBU: o_ldata = {24'h00_0000, w_shifted[7:0]};
        LH: begin
          o_ldata      = {{16{w_shifted[15]}}, w_shifted[15:0]};
          o_misaligned = i_offset[0];
        end
        LHU: begin
          o_ldata      = {16'h0000, w_shifted[15:0]};
          o_misaligned = i_offset[0];
        end
        LW: begin
          o_ldata      = i_rdata;
          o_misaligned = |i_offset;
        end
        default: o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: accepts one pipeline request, runs a word-aligned
// handshake on the data-memory port, and returns an aligned/extended response.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        data_mem_read,
  output logic        data_mem_write,
  output logic [3:0]  data_mbe,
  output logic [31:0] data_mem_address,
  output logic [31:0] data_mem_wdata,
  input  logic        data_mem_resp,
  input  logic [31:0] data_mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);

  lsu_state_t   r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [31:0]  r_addr, r_wdata, r_rsp_rdata;
  logic [2:0]   r_funct3;
  logic [3:0]   r_mbe;
  logic         r_read, r_write, r_rsp_err;
  logic         w_idle, w_bad_req, w_timeout;
  logic [2:0]   w_funct3;
  logic [1:0]   w_offset;
  logic         w_store;
  logic [3:0]   w_mbe;
  logic [31:0]  w_wdata, w_ldata;
  logic         w_misaligned, w_illegal;

  // In IDLE the lane logic decodes the incoming request; afterwards it
  // decodes the captured one so load extraction uses the held offset.
  assign w_idle   = (r_state == IDLE);
  assign w_funct3 = w_idle ? req_funct3    : r_funct3;
  assign w_offset = w_idle ? req_addr[1:0] : r_addr[1:0];
  assign w_store  = w_idle ? req_write     : r_write;

  mem_stage_lsu_align u_align (
    .i_funct3     (w_funct3),
    .i_offset     (w_offset),
    .i_store      (w_store),
    .i_wdata      (req_wdata),
    .i_rdata      (data_mem_rdata),
    .o_mbe        (w_mbe),
    .o_wdata      (w_wdata),
    .o_ldata      (w_ldata),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  assign w_bad_req  = w_misaligned | w_illegal | (req_read == req_write);
  assign w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_timeout  = (TIMEOUT != 0) && (w_cnt_next == LP_TIMEOUT);

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) w_state_next = w_bad_req ? RESP : ACCESS;
        else           w_state_next = IDLE;
      end
      ACCESS: begin
        if (data_mem_resp || w_timeout) w_state_next = RESP;
        else                            w_state_next = ACCESS;
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Request capture, timeout counter and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_addr      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_funct3    <= 3'b000;
      r_mbe       <= 4'b0000;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_cnt    <= '0;
            r_addr   <= req_addr;
            r_wdata  <= w_wdata;
            r_funct3 <= req_funct3;
            r_mbe    <= w_mbe;
            r_read   <= req_read;
            r_write  <= req_write;
            if (w_bad_req) begin
              r_rsp_rdata <= 32'h0000_0000;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (data_mem_resp) begin
            r_rsp_rdata <= r_write ? 32'h0000_0000 : w_ldata;
            r_rsp_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready        = w_idle;
  assign stall            = ~w_idle;
  assign rsp_valid        = (r_state == RESP);
  assign data_mem_read    = (r_state == ACCESS) & r_read;
  assign data_mem_write   = (r_state == ACCESS) & r_write;
  assign data_mbe         = r_mbe;
  assign data_mem_address = {r_addr[31:2], 2'b00};
  assign data_mem_wdata   = r_wdata;
  assign rsp_rdata        = r_rsp_rdata;
  assign rsp_err          = r_rsp_err;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: scoreboarded responses plus per-cycle
// checks of strobes, address, byte enables, store data and latency.
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_read, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        data_mem_read, data_mem_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_mem_address, data_mem_wdata;
  logic        data_mem_resp;
  logic [31:0] data_mem_rdata;
  logic        rsp_valid, rsp_err, stall;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .data_mem_read(data_mem_read), .data_mem_write(data_mem_write),
    .data_mbe(data_mbe), .data_mem_address(data_mem_address),
    .data_mem_wdata(data_mem_wdata), .data_mem_resp(data_mem_resp),
    .data_mem_rdata(data_mem_rdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    req_valid  = 1'b0;
    req_read   = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0000_0000;
    req_wdata  = 32'h0000_0000;
  endtask

  task automatic pop_and_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "/sb_nonempty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "/rsp_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "/rsp_err"}, {31'd0, rsp_err}, {31'd0, e.err});
    end
  endtask

  // One request: access=0 means rejected at accept, delay=0 means no memory response.
  task automatic txn(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input bit access,
                     input int delay, input logic [31:0] mem_rdata, input logic [31:0] exp_rdata,
                     input logic exp_err, input logic [3:0] exp_mbe, input logic [31:0] exp_wdata);
    int cyc, strobes, exp_strb;
    bit done;
    exp_t e;
    exp_strb = !access ? 0 : ((delay == 0) ? TO : delay);
    @(negedge clk);
    chk({tag, "/req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_read = rd; req_write = wr; req_funct3 = f3;
    req_addr = addr; req_wdata = wd;
    e.rdata = exp_rdata; e.err = exp_err;
    sb_q.push_back(e);
    @(posedge clk); #1;
    clear_req();
    cyc = 0; strobes = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      chk({tag, "/stall"}, {31'd0, stall}, 32'd1);
      if (data_mem_read || data_mem_write) begin
        strobes++;
        chk({tag, "/strobe_rd"}, {31'd0, data_mem_read}, {31'd0, rd});
        chk({tag, "/strobe_wr"}, {31'd0, data_mem_write}, {31'd0, wr});
        chk({tag, "/address"}, data_mem_address, {addr[31:2], 2'b00});
        chk({tag, "/mbe"}, {28'd0, data_mbe}, {28'd0, exp_mbe});
        if (wr) chk({tag, "/wdata"}, data_mem_wdata, exp_wdata);
        if (delay != 0 && strobes == delay) begin
          data_mem_resp  = 1'b1;
          data_mem_rdata = mem_rdata;
        end
      end
      if (rsp_valid) begin
        done = 1'b1;
        chk({tag, "/rsp_cycle"}, 32'(cyc), 32'(exp_strb + 1));
        chk({tag, "/strobe_cycles"}, 32'(strobes), 32'(exp_strb));
        pop_and_check(tag);
      end
      @(posedge clk); #1;
      data_mem_resp  = 1'b0;
      data_mem_rdata = $urandom;
    end
    if (!done) chk({tag, "/rsp_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    exp_t e;
    rst = 1'b0;
    clear_req();
    data_mem_resp  = 1'b0;
    data_mem_rdata = 32'h0000_0000;
    repeat (2) @(negedge clk);
    chk("rst/req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst/stall", {31'd0, stall}, 32'd0);
    chk("rst/rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst/strobes", {30'd0, data_mem_read, data_mem_write}, 32'd0);
    chk("rst/mbe", {28'd0, data_mbe}, 32'd0);
    chk("rst/address", data_mem_address, 32'd0);
    chk("rst/wdata", data_mem_wdata, 32'd0);
    chk("rst/rsp_rdata", rsp_rdata, 32'd0);
    chk("rst/rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b1;

    //   tag      rd    wr    f3      addr          wdata         acc  dly rdata          exp_rdata      err   mbe      exp_wdata
    txn("lw",    1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        1'b1, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0);
    txn("lb3",   1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        1'b1, 1, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 4'b1111, 32'h0);
    txn("lbu3",  1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        1'b1, 2, 32'h80FF_1234, 32'h0000_0080, 1'b0, 4'b1111, 32'h0);
    txn("lhu2",  1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        1'b1, 1, 32'h80FF_1234, 32'h0000_80FF, 1'b0, 4'b1111, 32'h0);
    txn("lh2",   1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        1'b1, 1, 32'h80FF_1234, 32'hFFFF_80FF, 1'b0, 4'b1111, 32'h0);
    txn("lb1",   1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        1'b1, 1, 32'h80FF_1234, 32'h0000_0012, 1'b0, 4'b1111, 32'h0);
    txn("sh6",   1'b0, 1'b1, 3'b001, 32'h0000_0206, 32'h0000_ABCD, 1'b1, 2, 32'hFFFF_FFFF, 32'h0,         1'b0, 4'b1100, 32'hABCD_ABCD);
    txn("sb1",   1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_005A, 1'b1, 1, 32'hFFFF_FFFF, 32'h0,         1'b0, 4'b0010, 32'h5A5A_5A5A);
    txn("sb3",   1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h1234_56C3, 1'b1, 1, 32'hFFFF_FFFF, 32'h0,         1'b0, 4'b1000, 32'hC3C3_C3C3);
    txn("sw",    1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h1234_5678, 1'b1, 1, 32'hFFFF_FFFF, 32'h0,         1'b0, 4'b1111, 32'h1234_5678);
    txn("lw_mis",1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        1'b0, 1, 32'hFFFF_FFFF, 32'h0,         1'b1, 4'b1111, 32'h0);
    txn("sh_mis",1'b0, 1'b1, 3'b001, 32'h0000_0103, 32'h0000_1111, 1'b0, 1, 32'hFFFF_FFFF, 32'h0,         1'b1, 4'b1111, 32'h0);
    txn("rd_wr", 1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0,        1'b0, 1, 32'hFFFF_FFFF, 32'h0,         1'b1, 4'b1111, 32'h0);
    txn("none",  1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        1'b0, 1, 32'hFFFF_FFFF, 32'h0,         1'b1, 4'b1111, 32'h0);
    txn("ld_f3", 1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        1'b0, 1, 32'hFFFF_FFFF, 32'h0,         1'b1, 4'b1111, 32'h0);
    txn("st_f3", 1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0,        1'b0, 1, 32'hFFFF_FFFF, 32'h0,         1'b1, 4'b1111, 32'h0);
    txn("tmo",   1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0,        1'b1, 0, 32'hFFFF_FFFF, 32'h0,         1'b1, 4'b1111, 32'h0);

    // Stray response after the timeout must not produce anything.
    @(negedge clk);
    data_mem_resp  = 1'b1;
    data_mem_rdata = 32'h1357_9BDF;
    repeat (2) begin
      @(negedge clk);
      chk("stray/rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("stray/strobes", {30'd0, data_mem_read, data_mem_write}, 32'd0);
      chk("stray/req_ready", {31'd0, req_ready}, 32'd1);
    end
    data_mem_resp = 1'b0;
    txn("lbu_after", 1'b1, 1'b0, 3'b100, 32'h0000_0401, 32'h0,   1'b1, 1, 32'h0000_C300, 32'h0000_00C3, 1'b0, 4'b1111, 32'h0);

    // Asynchronous reset in the middle of ACCESS.
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0500;
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    chk("mid_rst/strobe_before", {31'd0, data_mem_read}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst/strobe_async", {31'd0, data_mem_read}, 32'd0);
    chk("mid_rst/req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst/stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst/strobes", {30'd0, data_mem_read, data_mem_write}, 32'd0);
      chk("post_rst/rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("post_rst/req_ready", {31'd0, req_ready}, 32'd1);
    end
    txn("lw_post_rst", 1'b1, 1'b0, 3'b010, 32'h0000_0504, 32'h0, 1'b1, 2, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 4'b1111, 32'h0);

    // Request held valid through RESP must wait for IDLE.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h0000_0103; req_wdata = 32'h0000_1111;
    e.rdata = 32'h0; e.err = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_write = 1'b0; req_read = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0600;
    @(negedge clk);
    chk("resp_hold/rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("resp_hold/req_ready", {31'd0, req_ready}, 32'd0);
    chk("resp_hold/strobe", {31'd0, data_mem_read}, 32'd0);
    pop_and_check("resp_hold");
    @(negedge clk);
    chk("resp_hold/ready_next", {31'd0, req_ready}, 32'd1);
    chk("resp_hold/not_accepted", {31'd0, data_mem_read}, 32'd0);
    e.rdata = 32'hA5A5_0F0F; e.err = 1'b0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    chk("resp_hold/lw_strobe", {31'd0, data_mem_read}, 32'd1);
    chk("resp_hold/lw_addr", data_mem_address, 32'h0000_0600);
    data_mem_resp  = 1'b1;
    data_mem_rdata = 32'hA5A5_0F0F;
    @(posedge clk); #1;
    data_mem_resp = 1'b0;
    @(negedge clk);
    chk("resp_hold/lw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    pop_and_check("resp_hold_lw");

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
